// File: rtl/csr_trap_unit.sv
// rtl/csr_trap_unit.sv - machine-mode CSR file and trap sequencer for the RV32I core
module csr_trap_unit #(
  parameter logic [31:0] MTVEC_RST = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] instr,
  input  logic        instr_valid,
  input  logic [31:0] pc,
  input  logic [31:0] rs1_data,
  input  logic [2:0]  csr_alu_ctr,
  input  logic        csr_we,
  input  logic        irq_ext,
  output logic [31:0] csr_rdata,
  output logic        trap_valid,
  output logic [31:0] trap_pc,
  output logic        trap_squash
);

  localparam logic [11:0] A_MSTATUS  = 12'h300;
  localparam logic [11:0] A_MIE      = 12'h304;
  localparam logic [11:0] A_MTVEC    = 12'h305;
  localparam logic [11:0] A_MSCRATCH = 12'h340;
  localparam logic [11:0] A_MEPC     = 12'h341;
  localparam logic [11:0] A_MCAUSE   = 12'h342;
  localparam logic [11:0] A_MIP      = 12'h344;
  localparam logic [11:0] A_MCYCLE   = 12'hB00;
  localparam logic [11:0] A_MCYCLEH  = 12'hB80;
  localparam logic [11:0] A_CYCLE    = 12'hC00;
  localparam logic [11:0] A_CYCLEH   = 12'hC80;

  localparam logic [31:0] INSTR_ECALL = 32'h0000_0073;
  localparam logic [31:0] INSTR_MRET  = 32'h3020_0073;

  // Architectural state; low bits of mtvec/mepc are hard-wired zero so they are not stored
  logic        r_irq_s1;
  logic        r_irq_s2;
  logic        r_mie;
  logic        r_mpie;
  logic        r_meie;
  logic [29:0] r_mtvec;
  logic [29:0] r_mepc;
  logic [31:0] r_mscratch;
  logic [31:0] r_mcause;
  logic [31:0] r_mcycle;
  logic [31:0] r_mcycleh;

  logic [11:0] w_addr;
  logic [31:0] w_zimm;
  logic [31:0] w_old;
  logic [31:0] w_wdata;
  logic        w_op_ok;
  logic        w_take_int;
  logic        w_take_ecall;
  logic        w_take_mret;
  logic        w_csr_wr;
  logic        w_carry;

  assign w_addr = instr[31:20];
  assign w_zimm = {27'b0, instr[19:15]};

  // Read mux: old value of the addressed CSR, independent of instr_valid
  always_comb begin
    w_old = 32'b0;
    case (w_addr)
      A_MSTATUS:           w_old = {19'b0, 2'b11, 3'b0, r_mpie, 3'b0, r_mie, 3'b0};
      A_MIE:               w_old = {20'b0, r_meie, 11'b0};
      A_MTVEC:             w_old = {r_mtvec, 2'b00};
      A_MSCRATCH:          w_old = r_mscratch;
      A_MEPC:              w_old = {r_mepc, 2'b00};
      A_MCAUSE:            w_old = r_mcause;
      A_MIP:               w_old = {20'b0, r_irq_s2, 11'b0};
      A_MCYCLE, A_CYCLE:   w_old = r_mcycle;
      A_MCYCLEH, A_CYCLEH: w_old = r_mcycleh;
      default:             w_old = 32'b0;
    endcase
  end

  assign csr_rdata = w_old;

  // CSR ALU: new value from old value and register or immediate source
  always_comb begin
    w_op_ok = 1'b1;
    w_wdata = 32'b0;
    case (csr_alu_ctr)
      3'b010:  w_wdata = rs1_data;
      3'b100:  w_wdata = w_old | rs1_data;
      3'b001:  w_wdata = w_old & ~rs1_data;
      3'b011:  w_wdata = w_zimm;
      3'b101:  w_wdata = w_old | w_zimm;
      default: w_op_ok = 1'b0;
    endcase
  end

  // Trap arbitration: interrupt beats ecall beats mret, nothing happens while in reset
  assign w_take_int   = ~rst & instr_valid & r_irq_s2 & r_mie & r_meie;
  assign w_take_ecall = ~rst & instr_valid & ~w_take_int & (instr == INSTR_ECALL);
  assign w_take_mret  = ~rst & instr_valid & ~w_take_int & ~w_take_ecall & (instr == INSTR_MRET);

  assign trap_valid  = w_take_int | w_take_ecall | w_take_mret;
  assign trap_squash = w_take_int;
  assign trap_pc     = w_take_mret ? {r_mepc, 2'b00} : {r_mtvec, 2'b00};

  assign w_csr_wr = instr_valid & csr_we & w_op_ok & ~w_take_int;
  assign w_carry  = (r_mcycle == 32'hFFFF_FFFF);

  // State update: counter and sync flops always run; trap updates are applied last so they win
  always_ff @(posedge clk) begin
    if (rst) begin
      r_irq_s1   <= 1'b0;
      r_irq_s2   <= 1'b0;
      r_mie      <= 1'b0;
      r_mpie     <= 1'b0;
      r_meie     <= 1'b0;
      r_mtvec    <= MTVEC_RST[31:2];
      r_mepc     <= 30'b0;
      r_mscratch <= 32'b0;
      r_mcause   <= 32'b0;
      r_mcycle   <= 32'b0;
      r_mcycleh  <= 32'b0;
    end else begin
      r_irq_s1 <= irq_ext;
      r_irq_s2 <= r_irq_s1;

      if (w_csr_wr && w_addr == A_MCYCLE) r_mcycle <= w_wdata;
      else                                r_mcycle <= r_mcycle + 32'd1;

      if (w_csr_wr && w_addr == A_MCYCLEH) r_mcycleh <= w_wdata;
      else                                 r_mcycleh <= r_mcycleh + {31'b0, w_carry};

      if (w_csr_wr) begin
        case (w_addr)
          A_MSTATUS: begin
            r_mie  <= w_wdata[3];
            r_mpie <= w_wdata[7];
          end
          A_MIE:      r_meie     <= w_wdata[11];
          A_MTVEC:    r_mtvec    <= w_wdata[31:2];
          A_MSCRATCH: r_mscratch <= w_wdata;
          A_MEPC:     r_mepc     <= w_wdata[31:2];
          A_MCAUSE:   r_mcause   <= w_wdata;
          default:    ;
        endcase
      end

      if (w_take_int || w_take_ecall) begin
        r_mepc   <= pc[31:2];
        r_mcause <= w_take_int ? 32'h8000_000B : 32'd11;
        r_mpie   <= r_mie;
        r_mie    <= 1'b0;
      end else if (w_take_mret) begin
        r_mie  <= r_mpie;
        r_mpie <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_csr_trap_unit.sv
// tb/tb_csr_trap_unit.sv - directed self-checking bench for csr_trap_unit
module tb_csr_trap_unit;

  localparam logic [31:0] MTVEC_RST = 32'h0000_0400;
  localparam logic [31:0] ECALL     = 32'h0000_0073;
  localparam logic [31:0] MRET      = 32'h3020_0073;
  localparam logic [31:0] NOP       = 32'h0000_0013;

  logic        clk;
  logic        rst;
  logic [31:0] instr;
  logic        instr_valid;
  logic [31:0] pc;
  logic [31:0] rs1_data;
  logic [2:0]  csr_alu_ctr;
  logic        csr_we;
  logic        irq_ext;
  logic [31:0] csr_rdata;
  logic        trap_valid;
  logic [31:0] trap_pc;
  logic        trap_squash;

  int vecs = 0;
  int errs = 0;

  csr_trap_unit #(.MTVEC_RST(MTVEC_RST)) dut (
    .clk         (clk),
    .rst         (rst),
    .instr       (instr),
    .instr_valid (instr_valid),
    .pc          (pc),
    .rs1_data    (rs1_data),
    .csr_alu_ctr (csr_alu_ctr),
    .csr_we      (csr_we),
    .irq_ext     (irq_ext),
    .csr_rdata   (csr_rdata),
    .trap_valid  (trap_valid),
    .trap_pc     (trap_pc),
    .trap_squash (trap_squash)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [31:0] csr_i(input logic [11:0] a, input logic [4:0] z);
    return {a, z, 3'b001, 5'd1, 7'h73};
  endfunction

  task automatic drive(input logic [31:0] i, input logic v, input logic [31:0] p,
                       input logic [31:0] r, input logic [2:0] c, input logic w);
    instr = i; instr_valid = v; pc = p; rs1_data = r; csr_alu_ctr = c; csr_we = w;
  endtask

  task automatic peek(input logic [11:0] a);
    drive(csr_i(a, 5'd0), 1'b0, 32'h0, 32'h0, 3'b000, 1'b0);
    #1;
  endtask

  task automatic test_reset;
    rst = 1'b1; irq_ext = 1'b0;
    drive(ECALL, 1'b1, 32'h40, 32'h0, 3'b000, 1'b0);
    #1;
    vecs++; if (trap_valid !== 1'b0) begin errs++; $display("FAIL rst_trap_valid: got %b want 0", trap_valid); end
    repeat (3) @(negedge clk);
    rst = 1'b0;
    peek(12'h300); vecs++; if (csr_rdata !== 32'h0000_1800) begin errs++; $display("FAIL rst_mstatus: got %h want 00001800", csr_rdata); end
    peek(12'h305); vecs++; if (csr_rdata !== MTVEC_RST) begin errs++; $display("FAIL rst_mtvec: got %h want %h", csr_rdata, MTVEC_RST); end
    peek(12'hB00); vecs++; if (csr_rdata !== 32'h0) begin errs++; $display("FAIL rst_mcycle: got %h want 0", csr_rdata); end
    peek(12'h7C0); vecs++; if (csr_rdata !== 32'h0) begin errs++; $display("FAIL unknown_read: got %h want 0", csr_rdata); end
    @(negedge clk);
  endtask

  task automatic test_csr_ops;
    drive(csr_i(12'h340, 5'd2), 1'b1, 32'h10, 32'hDEAD_BEEF, 3'b010, 1'b1); #1;
    vecs++; if (csr_rdata !== 32'h0) begin errs++; $display("FAIL csrrw_old: got %h want 0", csr_rdata); end
    @(negedge clk);
    peek(12'h340); vecs++; if (csr_rdata !== 32'hDEAD_BEEF) begin errs++; $display("FAIL mscratch_rw: got %h want deadbeef", csr_rdata); end
    drive(csr_i(12'h340, 5'd2), 1'b1, 32'h14, 32'hFFFF_FFFF, 3'b100, 1'b1);
    @(negedge clk);
    drive(csr_i(12'h340, 5'd2), 1'b1, 32'h18, 32'h0000_00FF, 3'b001, 1'b1); #1;
    vecs++; if (csr_rdata !== 32'hFFFF_FFFF) begin errs++; $display("FAIL csrrs_result: got %h want ffffffff", csr_rdata); end
    @(negedge clk);
    peek(12'h340); vecs++; if (csr_rdata !== 32'hFFFF_FF00) begin errs++; $display("FAIL csrrc_result: got %h want ffffff00", csr_rdata); end
    drive(csr_i(12'h340, 5'd2), 1'b0, 32'h1C, 32'h0, 3'b010, 1'b1);
    @(negedge clk);
    peek(12'h340); vecs++; if (csr_rdata !== 32'hFFFF_FF00) begin errs++; $display("FAIL invalid_no_write: got %h want ffffff00", csr_rdata); end
  endtask

  task automatic test_ecall_mret;
    drive(csr_i(12'h305, 5'h13), 1'b1, 32'h20, 32'h0, 3'b011, 1'b1);
    @(negedge clk);
    peek(12'h305); vecs++; if (csr_rdata !== 32'h10) begin errs++; $display("FAIL mtvec_wi: got %h want 00000010", csr_rdata); end
    drive(csr_i(12'h300, 5'h08), 1'b1, 32'h24, 32'h0, 3'b101, 1'b1);
    @(negedge clk);
    drive(csr_i(12'h304, 5'h00), 1'b1, 32'h28, 32'h0000_0800, 3'b100, 1'b1);
    @(negedge clk);
    peek(12'h300); vecs++; if (csr_rdata !== 32'h0000_1808) begin errs++; $display("FAIL mstatus_mie: got %h want 00001808", csr_rdata); end
    drive(ECALL, 1'b1, 32'h100, 32'h0, 3'b000, 1'b0); #1;
    vecs++; if (trap_valid !== 1'b1 || trap_squash !== 1'b0) begin errs++; $display("FAIL ecall_flags: got v=%b s=%b want v=1 s=0", trap_valid, trap_squash); end
    vecs++; if (trap_pc !== 32'h10) begin errs++; $display("FAIL ecall_pc: got %h want 00000010", trap_pc); end
    @(negedge clk);
    peek(12'h341); vecs++; if (csr_rdata !== 32'h100) begin errs++; $display("FAIL ecall_mepc: got %h want 00000100", csr_rdata); end
    peek(12'h342); vecs++; if (csr_rdata !== 32'd11) begin errs++; $display("FAIL ecall_mcause: got %h want 0000000b", csr_rdata); end
    peek(12'h300); vecs++; if (csr_rdata !== 32'h0000_1880) begin errs++; $display("FAIL ecall_mstatus: got %h want 00001880", csr_rdata); end
    @(negedge clk);
    drive(MRET, 1'b1, 32'h10, 32'h0, 3'b000, 1'b0); #1;
    vecs++; if (trap_valid !== 1'b1 || trap_pc !== 32'h100) begin errs++; $display("FAIL mret_pc: got v=%b pc=%h want v=1 pc=00000100", trap_valid, trap_pc); end
    @(negedge clk);
    peek(12'h300); vecs++; if (csr_rdata !== 32'h0000_1888) begin errs++; $display("FAIL mret_mstatus: got %h want 00001888", csr_rdata); end
    @(negedge clk);
  endtask

  task automatic test_interrupt;
    irq_ext = 1'b1;
    for (int k = 0; k < 2; k++) begin
      drive(NOP, 1'b1, 32'h1F8 + 32'(k * 4), 32'h0, 3'b000, 1'b0); #1;
      vecs++; if (trap_valid !== 1'b0) begin errs++; $display("FAIL irq_early_%0d: got %b want 0", k, trap_valid); end
      @(negedge clk);
    end
    drive(csr_i(12'h340, 5'd2), 1'b1, 32'h200, 32'h1234_5678, 3'b010, 1'b1); #1;
    vecs++; if (trap_valid !== 1'b1 || trap_squash !== 1'b1 || trap_pc !== 32'h10) begin errs++; $display("FAIL irq_take: got v=%b s=%b pc=%h want v=1 s=1 pc=00000010", trap_valid, trap_squash, trap_pc); end
    @(negedge clk);
    peek(12'h340); vecs++; if (csr_rdata !== 32'hFFFF_FF00) begin errs++; $display("FAIL irq_squash_write: got %h want ffffff00", csr_rdata); end
    peek(12'h342); vecs++; if (csr_rdata !== 32'h8000_000B) begin errs++; $display("FAIL irq_mcause: got %h want 8000000b", csr_rdata); end
    peek(12'h341); vecs++; if (csr_rdata !== 32'h200) begin errs++; $display("FAIL irq_mepc: got %h want 00000200", csr_rdata); end
    peek(12'h344); vecs++; if (csr_rdata !== 32'h800) begin errs++; $display("FAIL irq_mip: got %h want 00000800", csr_rdata); end
    @(negedge clk);
  endtask

  task automatic test_int_vs_ecall;
    drive(csr_i(12'h300, 5'h08), 1'b1, 32'h2F0, 32'h0, 3'b101, 1'b1); #1;
    vecs++; if (trap_valid !== 1'b0) begin errs++; $display("FAIL mie_off_no_trap: got %b want 0", trap_valid); end
    @(negedge clk);
    drive(ECALL, 1'b1, 32'h300, 32'h0, 3'b000, 1'b0); #1;
    vecs++; if (trap_squash !== 1'b1) begin errs++; $display("FAIL int_over_ecall: got %b want 1", trap_squash); end
    @(negedge clk);
    peek(12'h342); vecs++; if (csr_rdata !== 32'h8000_000B) begin errs++; $display("FAIL int_over_ecall_cause: got %h want 8000000b", csr_rdata); end
    drive(ECALL, 1'b1, 32'h304, 32'h0, 3'b000, 1'b0); #1;
    vecs++; if (trap_valid !== 1'b1 || trap_squash !== 1'b0) begin errs++; $display("FAIL ecall_mie0: got v=%b s=%b want v=1 s=0", trap_valid, trap_squash); end
    @(negedge clk);
    peek(12'h342); vecs++; if (csr_rdata !== 32'd11) begin errs++; $display("FAIL ecall_mie0_cause: got %h want 0000000b", csr_rdata); end
    peek(12'h341); vecs++; if (csr_rdata !== 32'h304) begin errs++; $display("FAIL ecall_mie0_mepc: got %h want 00000304", csr_rdata); end
    irq_ext = 1'b0;
    repeat (3) @(negedge clk);
  endtask

  task automatic test_counter;
    drive(csr_i(12'hB00, 5'd2), 1'b1, 32'h400, 32'hFFFF_FFFE, 3'b010, 1'b1);
    @(negedge clk);
    drive(csr_i(12'hB80, 5'd2), 1'b1, 32'h404, 32'h0, 3'b010, 1'b1);
    @(negedge clk);
    drive(NOP, 1'b0, 32'h408, 32'h0, 3'b000, 1'b0);
    @(negedge clk);
    peek(12'hB00); vecs++; if (csr_rdata !== 32'h0) begin errs++; $display("FAIL carry_lo: got %h want 0", csr_rdata); end
    peek(12'hC80); vecs++; if (csr_rdata !== 32'h1) begin errs++; $display("FAIL carry_hi: got %h want 1", csr_rdata); end
    @(negedge clk);
    drive(csr_i(12'hB00, 5'd2), 1'b1, 32'h40C, 32'd100, 3'b010, 1'b1);
    @(negedge clk);
    drive(csr_i(12'hC00, 5'd2), 1'b1, 32'h410, 32'h0, 3'b010, 1'b1); #1;
    vecs++; if (csr_rdata !== 32'd100) begin errs++; $display("FAIL cycle_alias: got %h want 00000064", csr_rdata); end
    @(negedge clk);
    peek(12'hC00); vecs++; if (csr_rdata !== 32'd101) begin errs++; $display("FAIL cycle_ro: got %h want 00000065", csr_rdata); end
    drive(csr_i(12'h7C0, 5'd2), 1'b1, 32'h414, 32'hFFFF_FFFF, 3'b010, 1'b1);
    @(negedge clk);
    peek(12'h7C0); vecs++; if (csr_rdata !== 32'h0) begin errs++; $display("FAIL unknown_write: got %h want 0", csr_rdata); end
  endtask

  task automatic test_reset_mid_trap;
    rst = 1'b1;
    drive(ECALL, 1'b1, 32'h500, 32'h0, 3'b000, 1'b0); #1;
    vecs++; if (trap_valid !== 1'b0 || trap_squash !== 1'b0) begin errs++; $display("FAIL rst_ecall: got v=%b s=%b want 0 0", trap_valid, trap_squash); end
    @(negedge clk);
    rst = 1'b0;
    peek(12'h341); vecs++; if (csr_rdata !== 32'h0) begin errs++; $display("FAIL rst_mepc: got %h want 0", csr_rdata); end
    peek(12'h342); vecs++; if (csr_rdata !== 32'h0) begin errs++; $display("FAIL rst_mcause: got %h want 0", csr_rdata); end
    peek(12'h300); vecs++; if (csr_rdata !== 32'h0000_1800) begin errs++; $display("FAIL rst2_mstatus: got %h want 00001800", csr_rdata); end
    peek(12'h305); vecs++; if (csr_rdata !== MTVEC_RST) begin errs++; $display("FAIL rst2_mtvec: got %h want %h", csr_rdata, MTVEC_RST); end
    @(negedge clk);
  endtask

  initial begin
    rst = 1'b1; irq_ext = 1'b0;
    drive(NOP, 1'b0, 32'h0, 32'h0, 3'b000, 1'b0);
    @(negedge clk);
    test_reset;
    test_csr_ops;
    test_ecall_mret;
    test_interrupt;
    test_int_vs_ecall;
    test_counter;
    test_reset_mid_trap;
    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end

endmodule
